// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Register offsets are relative to the block's BASE_ADDR.
package mmio_uart_tx_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } uart_tx_state_t;

    localparam logic [31:0] UART_DATA_OFFSET   = 32'h0000_0000;
    localparam logic [31:0] UART_STATUS_OFFSET = 32'h0000_0004;

    localparam int STS_BUSY_BIT  = 0;
    localparam int STS_EMPTY_BIT = 1;
    localparam int STS_FULL_BIT  = 2;
    localparam int STS_OVF_BIT   = 3;
    localparam int STS_COUNT_LSB = 8;

    function automatic logic [31:0] pack_status(
        input logic       busy,
        input logic       empty,
        input logic       full,
        input logic       ovf,
        input logic [7:0] count
    );
        logic [31:0] s;
        s                       = '0;
        s[STS_BUSY_BIT]         = busy;
        s[STS_EMPTY_BIT]        = empty;
        s[STS_FULL_BIT]         = full;
        s[STS_OVF_BIT]          = ovf;
        s[STS_COUNT_LSB +: 8]   = count;
        return s;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU store/load port as seen by the UART: store strobes/address/data in,
// load address in, STATUS value out.
interface mmio_uart_tx_if;
    import mmio_uart_tx_pkg::*;

    logic [3:0]  write;
    logic [31:0] write_address;
    logic [31:0] data_write;
    logic        read;
    logic [31:0] read_address;
    logic [31:0] data_read;

    modport master (
        output write,
        output write_address,
        output data_write,
        output read,
        output read_address,
        input  data_read
    );

    modport slave (
        input  write,
        input  write_address,
        input  data_write,
        input  read,
        input  read_address,
        output data_read
    );

endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full and a pop while
// empty are ignored; the caller decides how to report an overflow.
module mmio_uart_tx_sync_fifo
    import mmio_uart_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_COUNT);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA stores feed a byte FIFO, a
// baud-timed FSM serializes it on tx, STATUS is readable on the load port.
//
// state    | meaning
// TX_IDLE  | line high, waiting for a queued byte
// TX_START | start bit (low) for one bit time
// TX_DATA  | eight data bits, LSB first
// TX_STOP  | stop bit (high); chains straight into the next start if queued
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_4000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          tx_busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
    localparam logic [31:0]   DATA_ADDR   = BASE_ADDR + UART_DATA_OFFSET;
    localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + UART_STATUS_OFFSET;

    uart_tx_state_t state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     idx_q, idx_d;
    logic           tx_q, tx_d;
    logic           ovf_q, ovf_d;

    logic           push;
    logic           pop;
    logic           ovf_clear;
    logic           status_sel;
    logic           fifo_empty;
    logic           fifo_full;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic           unused_data_hi;

    assign push       = bus.write[0] && (bus.write_address == DATA_ADDR);
    assign ovf_clear  = (bus.write != 4'b0000) && (bus.write_address == STATUS_ADDR);
    assign status_sel = bus.read && (bus.read_address == STATUS_ADDR);
    assign unused_data_hi = ^bus.data_write[31:8];

    assign bus.data_read = status_sel
        ? pack_status(tx_busy, fifo_empty, fifo_full, ovf_q, 8'(fifo_count))
        : 32'h0000_0000;

    assign tx      = tx_q;
    assign tx_busy = (state_q != TX_IDLE);

    mmio_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (bus.data_write[7:0]),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    // Fullness is judged on the registered count, so a same-cycle pop never
    // makes room for a push that arrives while full.
    always_comb begin
        ovf_d = ovf_q;
        if (push && fifo_full) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        tx_d    = 1'b1;

        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    baud_d  = BAUD_RELOAD;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                if (baud_q == '0) begin
                    baud_d  = BAUD_RELOAD;
                    idx_d   = 3'd0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (baud_q == '0) begin
                    baud_d = BAUD_RELOAD;
                    if (idx_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            TX_STOP: begin
                if (baud_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        baud_d  = BAUD_RELOAD;
                        state_d = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        // Line level is registered from the next state so it lines up with
        // state_q after the edge.
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stores queue expected bytes, a serial
// monitor decodes every frame on tx and checks it cycle by cycle.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h8000_4000;
    localparam logic [31:0] STS   = 32'h8000_4004;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx;
    logic tx_busy;
    int   cyc = 0;

    int assertions = 0;
    int failures   = 0;

    logic [7:0] exp_q[$];
    int         starts[$];
    int         frames_done = 0;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial monitor: pops an expected byte at each start bit, then checks
    // every cycle of the 10-bit frame and the mid-bit decoded byte.
    initial begin
        logic       active;
        logic       bad;
        int         fc;
        int         errs;
        logic [9:0] pat;
        logic [9:0] rx;
        active = 1'b0;
        bad    = 1'b0;
        fc     = 0;
        errs   = 0;
        pat    = '1;
        rx     = '1;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 1'b0;
            end else begin
                if (!active && tx === 1'b0) begin
                    active = 1'b1;
                    fc     = 0;
                    errs   = 0;
                    rx     = '1;
                    starts.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        bad = 1'b1;
                        assertions++;
                        failures++;
                        $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
                    end else begin
                        bad = 1'b0;
                        pat = {1'b1, exp_q.pop_front(), 1'b0};
                    end
                end
                if (active) begin
                    if (!bad && (tx !== pat[fc / CPB] || tx_busy !== 1'b1)) errs++;
                    if ((fc % CPB) == CPB / 2) rx[fc / CPB] = tx;
                    fc++;
                    if (fc == 10 * CPB) begin
                        active = 1'b0;
                        frames_done++;
                        if (!bad) begin
                            assertions++;
                            if (rx !== pat) begin
                                failures++;
                                $display("FAIL frame_decode: got frame 0x%03h (byte 0x%02h) required 0x%03h (byte 0x%02h)",
                                         rx, rx[8:1], pat, pat[8:1]);
                            end
                            assertions++;
                            if (errs != 0) begin
                                failures++;
                                $display("FAIL frame_timing: byte 0x%02h had %0d bad tx/busy samples, required 0",
                                         pat[8:1], errs);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        assertions++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus.write         = strb;
        bus.write_address = addr;
        bus.data_write    = data;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.write         = 4'b0000;
        bus.write_address = '0;
        bus.data_write    = '0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.read         = 1'b1;
        bus.read_address = addr;
        #1;
        check(name, bus.data_read, exp);
        bus.read         = 1'b0;
        bus.read_address = '0;
    endtask

    task automatic wait_frames(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        assertions++;
        if (frames_done < target) begin
            failures++;
            $display("FAIL %s_timeout: got %0d frames required %0d", name, frames_done, target);
        end
    endtask

    function automatic int start_at(input int i);
        if (i < starts.size()) return starts[i];
        return -100000;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         p;
        int         si;
        int         fd;
        int         sc;
        int         n;
        logic [7:0] t4 [10];
        t4 = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h7E, 8'h99};

        bus.write         = 4'b0000;
        bus.write_address = '0;
        bus.data_write    = '0;
        bus.read          = 1'b0;
        bus.read_address  = '0;

        // 1: reset state
        repeat (3) @(negedge clk);
        rd_check("status_in_reset", STS, 32'h0000_0002);
        check("tx_in_reset", 32'(tx), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        rd_check("status_after_reset", STS, 32'h0000_0002);
        check("tx_idle", 32'(tx), 32'd1);
        check("busy_idle", 32'(tx_busy), 32'd0);

        // 2: single frame 0x55, latency and busy window
        si = starts.size();
        fd = frames_done;
        exp_q.push_back(8'h55);
        wr(BASE, 32'h0000_0055, 4'b0001);
        p = cyc;
        idle();
        wait_frames("t2", fd + 1, 100);
        check("t2_start_latency", start_at(si) - p, 32'd1);
        @(negedge clk);
        check("t2_busy_after_frame", 32'(tx_busy), 32'd0);
        check("t2_tx_after_frame", 32'(tx), 32'd1);

        // 3: three back-to-back frames with no idle gap
        si = starts.size();
        fd = frames_done;
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        wr(BASE, 32'hDEAD_BE41, 4'b0001);
        wr(BASE, 32'h0000_0042, 4'b0001);
        wr(BASE, 32'h1234_5643, 4'b1111);
        idle();
        wait_frames("t3", fd + 3, 200);
        check("t3_gap_1_2", start_at(si + 1) - start_at(si), 32'd40);
        check("t3_gap_2_3", start_at(si + 2) - start_at(si + 1), 32'd40);
        @(negedge clk);
        check("t3_busy_after", 32'(tx_busy), 32'd0);

        // 4: overflow with ten stores, then clear
        fd = frames_done;
        for (int i = 0; i < 9; i++) exp_q.push_back(t4[i]);
        for (int i = 0; i < 10; i++) wr(BASE, {24'h0, t4[i]}, 4'b0001);
        idle();
        rd_check("t4_status_full_ovf", STS, 32'h0000_080D);
        wr(STS, 32'h0000_0000, 4'b0001);
        idle();
        rd_check("t4_status_ovf_cleared", STS, 32'h0000_0805);
        wait_frames("t4", fd + 9, 500);
        check("t4_all_bytes_sent", exp_q.size(), 32'd0);
        @(negedge clk);
        rd_check("t4_status_drained", STS, 32'h0000_0002);

        // 5: reset mid-frame with three bytes queued
        si = starts.size();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        wr(BASE, 32'h0000_0000, 4'b0001);
        wr(BASE, 32'h0000_0011, 4'b0001);
        wr(BASE, 32'h0000_0022, 4'b0001);
        wr(BASE, 32'h0000_0033, 4'b0001);
        idle();
        n = 0;
        while (starts.size() <= si && n < 20) begin
            @(negedge clk);
            n++;
        end
        while (cyc < start_at(si) + 15 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t5_tx_low_before_reset", 32'(tx), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("t5_tx_high_in_reset", 32'(tx), 32'd1);
        check("t5_busy_low_in_reset", 32'(tx_busy), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rd_check("t5_status_after_reset", STS, 32'h0000_0002);
        sc = starts.size();
        repeat (60) @(negedge clk);
        check("t5_no_frames_after_reset", starts.size(), sc);
        check("t5_tx_idle", 32'(tx), 32'd1);

        // 6: accesses that must not push or read back
        sc = starts.size();
        wr(BASE, 32'h0000_6666, 4'b0010);
        idle();
        rd_check("t6_lane1_no_push", STS, 32'h0000_0002);
        wr(BASE + 32'h8, 32'h0000_0066, 4'b0001);
        idle();
        rd_check("t6_other_addr_no_push", STS, 32'h0000_0002);
        rd_check("t6_data_load_zero", BASE, 32'h0000_0000);
        bus.read         = 1'b0;
        bus.read_address = STS;
        #1;
        check("t6_status_unselected", bus.data_read, 32'h0000_0000);
        bus.read_address = '0;
        repeat (20) @(negedge clk);
        check("t6_no_frames", starts.size(), sc);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the CPU data bus. It sits directly downstream of the core's store port and replaces the simulation-only character sink with synthesizable logic. CPU stores to the DATA register push bytes into a small FIFO. A TX state machine serializes them as 8N1 frames on `tx`. A STATUS register is readable on the load port.

Parameters:
BASE_ADDR, 32'h80004000, address of the DATA register; STATUS is at BASE_ADDR+4.
CLKS_PER_BIT, 16, clock cycles per serial bit. Must be ≥2.
FIFO_DEPTH, 8, byte FIFO entries. Must be a power of 2 and ≥2.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
write  in  4  byte-lane write strobes from the core
write_address  in  32  store address
data_write  in  32  store data
read  in  1  load enable
read_address  in  32  load address
data_read  out  32  STATUS value when selected, else 0
tx  out  1  serial output; idles high
tx_busy  out  1  high while a frame is on the line

Behaviour:
- Reset (async, while reset=1):
  - tx=1, tx_busy=0, FIFO empty, count=0, overflow=0, state=TX_IDLE, baud counter=0.
  - data_read follows combinationally and therefore reads 0x00000002 on a STATUS load.
- Push:
  - Condition: write[0]=1 and write_address==BASE_ADDR.
  - data_write[7:0] is enqueued at that clock edge.
  - Other lanes are ignored. If write[0]=0 there is no push.
- Full:
  - If the FIFO is full at the edge (registered count), the push is dropped and overflow is set (sticky).
  - This applies even if a pop happens in the same cycle.
- Push and pop in the same cycle with the FIFO not full: both happen and count is unchanged.
- Overflow clear: any write with write!=0 to BASE_ADDR+4 clears overflow.
- STATUS read (combinational):
  - Selected when read=1 and read_address==BASE_ADDR+4.
  - Layout: bit0 tx_busy, bit1 empty, bit2 full, bit3 overflow, bits[15:8] count, all other bits 0.
  - A read of DATA or any other address returns 0.
- TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_STOP.
  - TX_IDLE: tx=1. If FIFO non-empty: pop into an 8-bit shift register, load baud counter with CLKS_PER_BIT-1, go to TX_START.
  - TX_START: tx=0 for CLKS_PER_BIT cycles, then go to TX_DATA with bit index 0.
  - TX_DATA: tx=shift[0], LSB first. Every CLKS_PER_BIT cycles shift right and increment the index. After index 7 completes, go to TX_STOP.
  - TX_STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to TX_START (no idle gap); else go to TX_IDLE.
  - tx is registered and driven from state/shift.
- Latency: push at edge N → pop at edge N+1 → tx falls after edge N+1. Frame length is 10·CLKS_PER_BIT cycles.
- tx_busy=1 in every state except TX_IDLE.
- Baud counter: counts down from CLKS_PER_BIT-1. A bit ends when it reaches 0. Width is $clog2(CLKS_PER_BIT).
- Count width is $clog2(FIFO_DEPTH)+1. Read/write pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame aborts the frame: tx=1 immediately and asynchronously, and all queued bytes are lost.

Decomposition:
- Shared package:
  - typedef enum logic [1:0] uart_tx_state_t {TX_IDLE, TX_START, TX_DATA, TX_STOP}
  - constants UART_DATA_OFFSET=0, UART_STATUS_OFFSET=4
  - STATUS bit-index constants
- One sub-module: sync_fifo. It is parameterized on width and depth and provides push, pop, dout, empty, full, count, with async active-high reset.
- The top holds the bus decode, STATUS mux, baud counter and FSM.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8):
1. Reset, then STATUS load → data_read=0x00000002, tx=1, tx_busy=0.
2. Store 0x00000055 to 0x80004000 with write=4'b0001.
   - tx falls 1 cycle after the push edge.
   - Bits are 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), 4 cycles each.
   - tx_busy is high for 40 cycles, then low.
3. Store 0x41, 0x42, 0x43 on consecutive cycles → three contiguous frames totalling 120 cycles with no idle cycle between stop and start. Decoded bytes are 0x41, 0x42, 0x43.
4. Store 10 bytes back-to-back.
   - Byte 1 is popped after 1 cycle; the next 8 fill the FIFO; byte 10 is dropped.
   - STATUS = count 8, full=1, overflow=1, busy=1, i.e. 0x0000080D.
   - A store to 0x80004004 → overflow=0 (STATUS 0x00000805).
5. Assert reset 15 cycles into a frame with 3 bytes queued → tx=1 immediately. After release: STATUS=0x00000002 and no further frames.
6. Ignored accesses:
   - Store to 0x80004000 with write=4'b0010 → no push (count stays 0).
   - Store to 0x80004008 → no push.
   - Load from 0x80004000 → data_read=0.
